// File: rtl/tow_pkg.sv
// ----------------------------------------------------------------------------
// tow_pkg: shared types and helpers for the tug-of-war round controller. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tow_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_GO   = 3'd2,
      ST_HOLD = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   localparam int PRIO_FIXED  = 0;
   localparam int PRIO_ROTATE = 1;
   localparam int PRIO_TIE    = 2;

   // Player index width, never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tow_prio_pick.sv
// ----------------------------------------------------------------------------
// tow_prio_pick: first set request at or after a start pointer, wrapping. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tow_prio_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         found_o,
   output logic [W-1:0] idx_o,
   output logic         multi_o
);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;

   // Rotating the doubled vector right by ptr puts the pointer position at bit 0.
   assign w_dbl   = {req_i, req_i} >> ptr_i;
   assign w_rot   = w_dbl[N-1:0];
   assign multi_o = |(req_i & (req_i - N'(1)));

   always_comb begin
      int s;
      s       = 0;
      found_o = 1'b0;
      idx_o   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found_o && w_rot[k]) begin
            found_o = 1'b1;
            s       = int'(ptr_i) + k;
            if (s >= N) begin
               s = s - N;
            end
            idx_o   = W'(s);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/tow_round_arbiter.sv
// ----------------------------------------------------------------------------
// tow_round_arbiter: N-player round sequencer, first-press arbiter and scorer. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tow_round_arbiter
   import tow_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 7,
   parameter int DELAY_W     = 8,
   parameter int GO_TIMEOUT  = 200,
   parameter int HOLD_TICKS  = 64,
   parameter int PRIO_MODE   = 0,
   localparam int ID_W       = id_w(NUM_PLAYERS)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic [DELAY_W-1:0]             rand_in,
   input  logic                           start,
   input  logic [NUM_PLAYERS-1:0]         pb,
   output logic                           go_lamp,
   output logic                           busy,
   output logic                           winner_valid,
   output logic [ID_W-1:0]                winner_id,
   output logic [NUM_PLAYERS-1:0]         false_start,
   output logic                           void_round,
   output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
   output logic                           match_over,
   output logic [ID_W-1:0]                champion_id
);

   localparam int GO_W   = $clog2(GO_TIMEOUT + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int MAX_GH = (GO_W >= HOLD_W) ? GO_W : HOLD_W;
   localparam int TMR_W  = (DELAY_W >= MAX_GH) ? DELAY_W : MAX_GH;

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
   localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);

   state_e                 state_q, state_d;
   logic [TMR_W-1:0]       tmr_q, tmr_d, w_seed;
   logic [NUM_PLAYERS-1:0] pb_q, fs_q, fs_d, w_rise;
   logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
   logic [ID_W-1:0]        ptr_q, ptr_d, win_id_q, win_id_d;
   logic [ID_W-1:0]        w_pick_ptr, w_pick_idx, w_ptr_next;
   logic                   win_valid_q, win_valid_d, void_q, void_d;
   logic                   w_found, w_multi, w_any_win;

   assign w_rise     = pb & ~pb_q;
   assign w_seed     = (rand_in == '0) ? TMR_ONE : TMR_W'(rand_in);
   assign w_pick_ptr = (PRIO_MODE == PRIO_ROTATE) ? ptr_q : '0;
   assign w_ptr_next = (w_pick_idx == ID_W'(NUM_PLAYERS - 1)) ? '0 : w_pick_idx + ID_W'(1);

   tow_prio_pick #(
      .N (NUM_PLAYERS),
      .W (ID_W)
   ) u_pick (
      .req_i   (w_rise),
      .ptr_i   (w_pick_ptr),
      .found_o (w_found),
      .idx_o   (w_pick_idx),
      .multi_o (w_multi)
   );

   always_comb begin
      w_any_win = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (score_q[i] >= SCORE_WIN) begin
            w_any_win = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         pb_q        <= '0;
         fs_q        <= '0;
         score_q     <= '{default: '0};
         ptr_q       <= '0;
         win_id_q    <= '0;
         win_valid_q <= 1'b0;
         void_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         pb_q        <= pb;
         fs_q        <= fs_d;
         score_q     <= score_d;
         ptr_q       <= ptr_d;
         win_id_q    <= win_id_d;
         win_valid_q <= win_valid_d;
         void_q      <= void_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      fs_d        = fs_q;
      score_d     = score_q;
      ptr_d       = ptr_q;
      win_id_d    = win_id_q;
      win_valid_d = 1'b0;
      void_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               tmr_d   = w_seed;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // An early press outranks a GO-triggering tick in the same cycle.
            if (w_found) begin
               fs_d = fs_q | w_rise;
               for (int i = 0; i < NUM_PLAYERS; i++) begin
                  if (w_rise[i] && (score_q[i] != '0)) begin
                     score_d[i] = score_q[i] - SCORE_W'(1);
                  end
               end
               tmr_d   = TMR_W'(HOLD_TICKS);
               state_d = ST_HOLD;
            end else if (tick) begin
               if (tmr_q == TMR_ONE) begin
                  tmr_d   = TMR_W'(GO_TIMEOUT);
                  state_d = ST_GO;
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
         end
         ST_GO: begin
            if (w_found) begin
               if ((PRIO_MODE == PRIO_TIE) && w_multi) begin
                  void_d = 1'b1;
               end else begin
                  win_valid_d = 1'b1;
                  win_id_d    = w_pick_idx;
                  if (score_q[w_pick_idx] != SCORE_MAX) begin
                     score_d[w_pick_idx] = score_q[w_pick_idx] + SCORE_W'(1);
                  end
                  if (PRIO_MODE == PRIO_ROTATE) begin
                     ptr_d = w_ptr_next;
                  end
               end
               tmr_d   = TMR_W'(HOLD_TICKS);
               state_d = ST_HOLD;
            end else if (tick) begin
               if (tmr_q == TMR_ONE) begin
                  void_d  = 1'b1;
                  tmr_d   = TMR_W'(HOLD_TICKS);
                  state_d = ST_HOLD;
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               if (tmr_q == TMR_ONE) begin
                  fs_d = '0;
                  if (w_any_win) begin
                     state_d = ST_DONE;
                  end else begin
                     tmr_d   = w_seed;
                     state_d = ST_WAIT;
                  end
               end else begin
                  tmr_d = tmr_q - TMR_ONE;
               end
            end
         end
         ST_DONE: begin
            if (start) begin
               score_d = '{default: '0};
               tmr_d   = w_seed;
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      go_lamp      = (state_q == ST_GO);
      busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
      match_over   = (state_q == ST_DONE);
      winner_valid = win_valid_q;
      winner_id    = win_id_q;
      void_round   = void_q;
      false_start  = fs_q;
      scores       = '0;
      champion_id  = '0;
      // Walk downwards so the lowest qualifying index is the one that sticks.
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         scores[i*SCORE_W +: SCORE_W] = score_q[i];
         if (match_over && (score_q[i] >= SCORE_WIN)) begin
            champion_id = ID_W'(i);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_tow_round_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tow_round_arbiter: directed checks for two-player and four-player rounds. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_tow_round_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic [7:0]  rand_in;
   logic        start2, start4;
   logic [1:0]  pb2;
   logic [3:0]  pb4;

   logic        go2, busy2, wv2, void2, mo2;
   logic [0:0]  wid2, champ2;
   logic [1:0]  fs2;
   logic [7:0]  sc2;

   logic        go_r, busy_r, wv_r, void_r, mo_r;
   logic [1:0]  wid_r, champ_r;
   logic [3:0]  fs_r;
   logic [15:0] sc_r;

   logic        go_t, busy_t, wv_t, void_t, mo_t;
   logic [1:0]  wid_t, champ_t;
   logic [3:0]  fs_t;
   logic [15:0] sc_t;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   tow_round_arbiter #(.NUM_PLAYERS(2), .PRIO_MODE(0)) dut2 (
      .clk(clk), .rst(rst), .tick(tick), .rand_in(rand_in), .start(start2), .pb(pb2),
      .go_lamp(go2), .busy(busy2), .winner_valid(wv2), .winner_id(wid2),
      .false_start(fs2), .void_round(void2), .scores(sc2), .match_over(mo2),
      .champion_id(champ2));

   tow_round_arbiter #(.NUM_PLAYERS(4), .PRIO_MODE(1)) dut4r (
      .clk(clk), .rst(rst), .tick(tick), .rand_in(rand_in), .start(start4), .pb(pb4),
      .go_lamp(go_r), .busy(busy_r), .winner_valid(wv_r), .winner_id(wid_r),
      .false_start(fs_r), .void_round(void_r), .scores(sc_r), .match_over(mo_r),
      .champion_id(champ_r));

   tow_round_arbiter #(.NUM_PLAYERS(4), .PRIO_MODE(2)) dut4t (
      .clk(clk), .rst(rst), .tick(tick), .rand_in(rand_in), .start(start4), .pb(pb4),
      .go_lamp(go_t), .busy(busy_t), .winner_valid(wv_t), .winner_id(wid_t),
      .false_start(fs_t), .void_round(void_t), .scores(sc_t), .match_over(mo_t),
      .champion_id(champ_t));

   // One-cycle tick every fourth clock, changing on the falling edge.
   initial begin
      tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      int c = 0;
      int g = 0;
      while (c < n && g < 4 * n + 8) begin
         @(posedge clk);
         if (tick) c++;
         #1;
         g++;
      end
      chk("wait_ticks_bound", 32'(c), 32'(n));
   endtask

   task automatic wait_go(input int which);
      int g = 0;
      while (((which == 0) ? go2 : go_r) !== 1'b1 && g < 3000) begin
         step();
         g++;
      end
      chk("wait_go_bound", 32'((which == 0) ? go2 : go_r), 32'd1);
   endtask

   task automatic pulse_start(input int which);
      @(negedge clk);
      if (which == 0) start2 = 1'b1; else start4 = 1'b1;
      step();
      @(negedge clk);
      start2 = 1'b0;
      start4 = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  pb;
      logic [1:0]  rid;
      logic [15:0] rsc;
      logic        tvoid;
      logic [1:0]  tid;
      logic [15:0] tsc;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int n;
      int g;
      logic saw_win;

      vecs[0] = '{pb: 4'b0101, rid: 2'd0, rsc: 16'h0001, tvoid: 1'b1, tid: 2'd0, tsc: 16'h0000};
      vecs[1] = '{pb: 4'b0101, rid: 2'd2, rsc: 16'h0101, tvoid: 1'b1, tid: 2'd0, tsc: 16'h0000};
      vecs[2] = '{pb: 4'b1000, rid: 2'd3, rsc: 16'h1101, tvoid: 1'b0, tid: 2'd3, tsc: 16'h1000};
      vecs[3] = '{pb: 4'b0110, rid: 2'd1, rsc: 16'h1111, tvoid: 1'b1, tid: 2'd0, tsc: 16'h1000};
      vecs[4] = '{pb: 4'b0011, rid: 2'd0, rsc: 16'h1112, tvoid: 1'b1, tid: 2'd0, tsc: 16'h1000};

      rst = 1'b1; rand_in = 8'd3; start2 = 1'b0; start4 = 1'b0; pb2 = '0; pb4 = '0;
      repeat (3) step();
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("rst_go_lamp", 32'(go2), 32'd0);
      chk("rst_busy", 32'(busy2), 32'd0);
      chk("rst_scores", 32'(sc2), 32'd0);
      chk("rst_flags", 32'({wv2, void2, fs2, mo2, wid2, champ2}), 32'd0);

      // Round 1: GO on the third tick, then an unanswered GO times out.
      pulse_start(0);
      chk("busy_after_start", 32'(busy2), 32'd1);
      n = 0; g = 0;
      while (go2 !== 1'b1 && g < 200) begin
         @(posedge clk);
         if (tick) n++;
         #1;
         g++;
      end
      chk("go_on_third_tick", 32'(n), 32'd3);
      n = 0; g = 0;
      while (void2 !== 1'b1 && g < 2000) begin
         @(posedge clk);
         if (tick) n++;
         #1;
         g++;
      end
      chk("timeout_ticks", 32'(n), 32'd200);
      chk("timeout_go_off", 32'(go2), 32'd0);
      chk("timeout_scores", 32'(sc2), 32'd0);
      step();
      chk("void_one_cycle", 32'(void2), 32'd0);

      // Round 2: player 1 jumps the gun in WAIT with score already 0.
      wait_ticks(64);
      @(negedge clk);
      pb2 = 2'b10;
      step();
      chk("fs_bits", 32'(fs2), 32'h2);
      chk("fs_no_winner", 32'(wv2), 32'd0);
      chk("fs_score_sat", 32'(sc2), 32'd0);
      chk("fs_busy", 32'({busy2, go2}), 32'h2);
      @(negedge clk);
      pb2 = 2'b00;
      wait_ticks(63);
      chk("fs_held_in_hold", 32'(fs2), 32'h2);
      wait_ticks(1);
      chk("fs_cleared", 32'(fs2), 32'd0);

      // Round 3: player 0 wins the GO.
      wait_go(0);
      @(negedge clk);
      pb2 = 2'b01;
      step();
      chk("win0_valid", 32'(wv2), 32'd1);
      chk("win0_id", 32'(wid2), 32'd0);
      chk("win0_score", 32'(sc2), 32'h01);
      chk("win0_go_off", 32'(go2), 32'd0);
      step();
      chk("win0_pulse_width", 32'(wv2), 32'd0);

      // Button 0 stays held from HOLD into the next GO: never a rise.
      wait_go(0);
      chk("held_no_false_start", 32'(fs2), 32'd0);
      saw_win = 1'b0;
      repeat (8) begin
         step();
         if (wv2) saw_win = 1'b1;
      end
      chk("held_no_win", 32'({saw_win, go2}), 32'h1);
      chk("pre_rst_score", 32'(sc2), 32'h01);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midgo_rst_go", 32'(go2), 32'd0);
      chk("midgo_rst_scores", 32'(sc2), 32'd0);
      chk("midgo_rst_flags", 32'({wv2, void2, fs2, mo2, busy2}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pb2 = 2'b00;

      // Match: player 1 takes seven rounds.
      pulse_start(0);
      for (int r = 0; r < 7; r++) begin
         wait_go(0);
         @(negedge clk);
         pb2 = 2'b10;
         step();
         chk("p1_round_win", 32'({wv2, wid2}), 32'h3);
         @(negedge clk);
         pb2 = 2'b00;
      end
      chk("p1_score_seven", 32'(sc2), 32'h70);
      wait_ticks(63);
      chk("match_not_yet", 32'(mo2), 32'd0);
      wait_ticks(1);
      chk("match_over", 32'(mo2), 32'd1);
      chk("champion", 32'(champ2), 32'd1);
      chk("done_not_busy", 32'(busy2), 32'd0);
      pulse_start(0);
      chk("new_match_scores", 32'(sc2), 32'd0);
      chk("new_match_flags", 32'({mo2, busy2, go2}), 32'h2);

      // Four players: rotating priority against tie policy, same stimulus.
      pulse_start(1);
      for (int v = 0; v < 5; v++) begin
         wait_go(1);
         chk("tie_go_in_step", 32'(go_t), 32'd1);
         @(negedge clk);
         pb4 = vecs[v].pb;
         step();
         chk("rot_valid", 32'({wv_r, void_r}), 32'h2);
         chk("rot_id", 32'(wid_r), 32'(vecs[v].rid));
         chk("rot_scores", 32'(sc_r), 32'(vecs[v].rsc));
         chk("tie_flags", 32'({wv_t, void_t}), 32'({~vecs[v].tvoid, vecs[v].tvoid}));
         if (!vecs[v].tvoid) chk("tie_id", 32'(wid_t), 32'(vecs[v].tid));
         chk("tie_scores", 32'(sc_t), 32'(vecs[v].tsc));
         @(negedge clk);
         pb4 = 4'b0000;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tow_round_arbiter.md
Name: tow_round_arbiter

Overview:
Parametrised N-player round controller for the tug-of-war game. It replaces the fixed two-button latch/scorer pair. It sequences each round through a random wait, a GO lamp, first-press arbitration with selectable tie policy, false-start penalties, per-player saturating scores and match-win detection. It sits between the synchronised push-button inputs and the LED mux, sound and VGA blocks.

Parameters:
NUM_PLAYERS, 2, number of player buttons (2..8)
SCORE_W, 4, bits per player score
WIN_SCORE, 7, score that ends the match (must be <= 2**SCORE_W-1)
DELAY_W, 8, width of random wait value
GO_TIMEOUT, 200, ticks in GO before the round is void
HOLD_TICKS, 64, ticks the result is held before the next round
PRIO_MODE, 0, simultaneous-press policy: 0 = lowest index wins, 1 = rotating priority, 2 = tie (no point)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  slow enable, one-cycle pulse from the divider
rand_in  in  DELAY_W  random wait value from the LFSR
start  in  1  one-cycle request to begin a round or a new match
pb  in  NUM_PLAYERS  synchronised, debounced buttons, active high
go_lamp  out  1  GO indicator
busy  out  1  state is not IDLE and not DONE
winner_valid  out  1  one-cycle pulse when a round is won
winner_id  out  ID_W  index of the round winner; ID_W = max(1, clog2(NUM_PLAYERS))
false_start  out  NUM_PLAYERS  players that pressed early in the current round
void_round  out  1  one-cycle pulse on timeout or tie
scores  out  NUM_PLAYERS*SCORE_W  packed scores, player i at bits [i*SCORE_W +: SCORE_W]
match_over  out  1  high while in DONE
champion_id  out  ID_W  index of the match winner, valid while match_over is high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; all outputs 0; scores 0; rotating pointer 0; pb history 0.
- Edge detection: pb_q is registered each cycle. rise = pb & ~pb_q. Only rises count. A button already held when GO is entered never wins.
- IDLE: start loads cnt = (rand_in==0 ? 1 : rand_in) and moves to WAIT.
- WAIT:
  - cnt decrements on tick. A tick with cnt==1 moves to GO with go_lamp=1 and loads the GO_TIMEOUT counter.
  - Any rise is a false start. Set those false_start bits. Decrement each offender's score, saturating at 0. Move to HOLD with no winner.
  - Multiple offenders in the same cycle are all penalised.
- GO:
  - First cycle with rise != 0 decides the round, all in the same edge: winner_valid=1 for one cycle, winner_id set, the winner's score +1 saturating at 2**SCORE_W-1, go_lamp=0, move to HOLD.
  - More than one rise in that cycle: PRIO_MODE 0 picks the lowest index. PRIO_MODE 1 picks the first set bit at or after ptr, wrapping; ptr then becomes winner+1 mod NUM_PLAYERS. PRIO_MODE 2 pulses void_round with no score change.
  - A timeout (GO_TIMEOUT ticks with no rise) pulses void_round and moves to HOLD.
- HOLD:
  - Count HOLD_TICKS ticks, then clear false_start.
  - If any score >= WIN_SCORE, move to DONE. Otherwise reload cnt from rand_in and return to WAIT (automatic next round).
- DONE:
  - match_over=1; champion_id = lowest index with score >= WIN_SCORE.
  - start clears all scores and match_over, loads cnt, and moves to WAIT.
- start is ignored in WAIT, GO and HOLD. pb is ignored in IDLE, HOLD and DONE.
- Latency: a rise sampled at edge N produces winner_valid high during the cycle after edge N. No extra pipeline.
- Reset mid-round: everything returns to reset values immediately, with no pulses.

Decomposition:
- Shared package tow_pkg holds:
  - the state enum (IDLE, WAIT, GO, HOLD, DONE);
  - PRIO_MODE constants (PRIO_FIXED, PRIO_ROTATE, PRIO_TIE);
  - the ID_W helper function.
- One sub-module, tow_prio_pick: combinational N-bit request vector plus start pointer in, found flag, index and multi-hit flag out. It serves both the fixed mode (pointer 0) and the rotating mode.

Test Plan:
- Reset, start with rand_in=3 and a tick every 4 cycles -> go_lamp rises on the 3rd tick. No press for GO_TIMEOUT ticks -> void_round pulses; scores stay 0.
- Player 1 presses during WAIT -> false_start=2'b10, score1 stays 0 (saturation), HOLD entered, no winner_valid.
- Player 0 rises in GO -> winner_valid for exactly 1 cycle, winner_id=0, scores[3:0]=1, go_lamp low on the same edge.
- NUM_PLAYERS=4, PRIO_MODE=1: players 0 and 2 rise together twice -> first winner 0, then 2. With PRIO_MODE=2 -> void_round, no score change.
- Player 1 wins 7 rounds (WIN_SCORE=7) -> after HOLD, match_over=1, champion_id=1. Next start -> all scores 0, state WAIT.
- Button held from IDLE through GO -> no win. Assert rst mid-GO -> go_lamp, scores and outputs are 0 immediately.
